// File: rtl/uio_port_arbiter.sv
// Round-robin arbiter that lends a shared bidirectional uio port to one requester per transfer.
// Each transfer is an XFER phase (drive or sample pins) followed by a TURN phase that releases the bus.
module uio_port_arbiter #(
    parameter int NREQ        = 3,
    parameter int HOLD_CYCLES = 2,
    parameter int TURNAROUND  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   wr,
    input  logic [8*NREQ-1:0] wdata,
    input  logic [7:0]        uio_in,
    output logic [7:0]        uio_out,
    output logic [7:0]        uio_oe,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic [7:0]        rdata,
    output logic              busy
);

    localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_MAX = (HOLD_CYCLES > TURNAROUND) ? HOLD_CYCLES : TURNAROUND;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_TURN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   win_q, win_d;
    logic               wr_q, wr_d;
    logic [7:0]         byte_q, byte_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [7:0]         oe_q, oe_d;
    logic [7:0]         out_q, out_d;
    logic               done_q, done_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               busy_q, busy_d;

    logic               rr_found;
    logic [IDX_W-1:0]   rr_win;
    logic               sel_wr;
    logic [7:0]         sel_byte;

    // win_q doubles as last_winner: the search starts just after it and wraps.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = win_q;
        for (int k = 1; k <= NREQ; k++) begin
            if (!rr_found && req[(int'(win_q) + k) % NREQ]) begin
                rr_found = 1'b1;
                rr_win   = IDX_W'((int'(win_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        sel_wr   = 1'b0;
        sel_byte = 8'h00;
        for (int i = 0; i < NREQ; i++) begin
            if (rr_win == IDX_W'(i)) begin
                sel_wr   = wr[i];
                sel_byte = wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        wr_d    = wr_q;
        byte_d  = byte_q;
        rdata_d = rdata_q;
        done_d  = 1'b0;
        gnt_d   = '0;
        oe_d    = 8'h00;
        out_d   = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (ena && rr_found) begin
                    state_d = S_XFER;
                    cnt_d   = CNT_W'(HOLD_CYCLES - 1);
                    win_d   = rr_win;
                    wr_d    = sel_wr;
                    byte_d  = sel_byte;
                end
            end
            S_XFER: begin
                if (cnt_q == '0) begin
                    state_d = S_TURN;
                    cnt_d   = CNT_W'(TURNAROUND - 1);
                    done_d  = 1'b1;
                    if (!wr_q) begin
                        rdata_d = uio_in;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_TURN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        if (state_d == S_XFER) begin
            for (int i = 0; i < NREQ; i++) begin
                gnt_d[i] = (win_d == IDX_W'(i));
            end
            if (wr_d) begin
                oe_d  = 8'hFF;
                out_d = byte_d;
            end
        end
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            win_q   <= IDX_W'(NREQ - 1);
            wr_q    <= 1'b0;
            byte_q  <= 8'h00;
            gnt_q   <= '0;
            oe_q    <= 8'h00;
            out_q   <= 8'h00;
            done_q  <= 1'b0;
            rdata_q <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            wr_q    <= wr_d;
            byte_q  <= byte_d;
            gnt_q   <= gnt_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt     = gnt_q;
    assign uio_oe  = oe_q;
    assign uio_out = out_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_uio_port_arbiter.sv
// Bench for uio_port_arbiter: directed transfers with a scoreboard of expected grants,
// pin activity and read data, checked by a monitor that runs independently of the stimulus.
module tb_uio_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  wr = 3'b000;
    logic [23:0] wdata = 24'h0;
    logic [7:0]  uio_in = 8'h00;
    logic [7:0]  uio_out;
    logic [7:0]  uio_oe;
    logic [2:0]  gnt;
    logic        done;
    logic [7:0]  rdata;
    logic        busy;

    uio_port_arbiter #(.NREQ(3), .HOLD_CYCLES(2), .TURNAROUND(1)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .wr(wr), .wdata(wdata),
        .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe), .gnt(gnt),
        .done(done), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] g;
        logic       w;
        logic [7:0] data;
        logic [7:0] rd;
    } item_t;

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    xfer_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [2:0] g, input logic w, input logic [7:0] data, input logic [7:0] rd);
        item_t e;
        e.g = g; e.w = w; e.data = data; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic wait_gnt(input logic [2:0] exp_g);
        int n = 0;
        @(negedge clk);
        while (gnt !== exp_g && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_gnt", 32'(gnt), 32'(exp_g));
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(busy), 32'd0);
    endtask

    // Monitor: per-cycle pin/grant checks against the head of the scoreboard, pop on done.
    always @(posedge clk) begin
        item_t e;
        #1;
        if (rst) begin
            if (xfer_cnt > 0 && sb.size() > 0) void'(sb.pop_front());
            xfer_cnt = 0;
        end else begin
            if (gnt != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 32'd0);
                end else begin
                    e = sb[0];
                    chk("xfer_gnt", 32'(gnt), 32'(e.g));
                    chk("xfer_oe", 32'(uio_oe), e.w ? 32'hFF : 32'h00);
                    chk("xfer_out", 32'(uio_out), e.w ? 32'(e.data) : 32'h00);
                end
                xfer_cnt++;
            end else begin
                chk("idle_oe", 32'(uio_oe), 32'h00);
                chk("idle_out", 32'(uio_out), 32'h00);
            end
            if (done) begin
                if (sb.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("xfer_len", 32'(xfer_cnt), 32'd2);
                    chk("done_rdata", 32'(rdata), 32'(e.rd));
                end
                xfer_cnt = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t[4];
        int ngr;
        int cyc;
        logic [2:0] prev_g;

        // Reset held two cycles with every requester asking.
        rst = 1'b1; req = 3'b111; ena = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_oe", 32'(uio_oe), 32'h00);
        chk("rst_out", 32'(uio_out), 32'h00);
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'h00);
        rst = 1'b0; req = 3'b000;
        @(negedge clk);

        // Write A5 by requester 0.
        req = 3'b001; wr = 3'b001; wdata[7:0] = 8'hA5;
        push(3'b001, 1'b1, 8'hA5, 8'h00);
        @(negedge clk);
        chk("w_t1_gnt", 32'(gnt), 32'b001);
        chk("w_t1_oe", 32'(uio_oe), 32'hFF);
        chk("w_t1_out", 32'(uio_out), 32'hA5);
        chk("w_t1_busy", 32'(busy), 32'd1);
        req = 3'b000;
        @(negedge clk);
        chk("w_t2_gnt", 32'(gnt), 32'b001);
        chk("w_t2_out", 32'(uio_out), 32'hA5);
        @(negedge clk);
        chk("w_t3_done", 32'(done), 32'd1);
        chk("w_t3_oe", 32'(uio_oe), 32'h00);
        chk("w_t3_gnt", 32'(gnt), 32'd0);
        @(negedge clk);
        chk("w_t4_busy", 32'(busy), 32'd0);
        chk("w_t4_done", 32'(done), 32'd0);

        // Read 3C by requester 1, then a write must leave rdata alone.
        req = 3'b010; wr = 3'b000; uio_in = 8'h3C;
        push(3'b010, 1'b0, 8'h3C, 8'h3C);
        wait_gnt(3'b010);
        req = 3'b000;
        wait_idle();
        chk("rd_rdata", 32'(rdata), 32'h3C);
        req = 3'b001; wr = 3'b001; wdata[7:0] = 8'h5A; uio_in = 8'h00;
        push(3'b001, 1'b1, 8'h5A, 8'h3C);
        wait_gnt(3'b001);
        req = 3'b000;
        wait_idle();
        chk("wr_keeps_rdata", 32'(rdata), 32'h3C);

        // Enable low: requester 2 waits, then is granted the cycle after ena rises.
        ena = 1'b0; req = 3'b100; wr = 3'b000; uio_in = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("ena0_gnt", 32'(gnt), 32'd0);
            chk("ena0_busy", 32'(busy), 32'd0);
        end
        ena = 1'b1;
        push(3'b100, 1'b0, 8'hC3, 8'hC3);
        @(negedge clk);
        chk("ena1_gnt", 32'(gnt), 32'b100);
        req = 3'b000;
        wait_idle();

        // All three requesting from reset: 001,010,100,001 every 4 cycles.
        rst = 1'b1; req = 3'b111; wr = 3'b101; wdata = 24'h33_22_11; uio_in = 8'h7E;
        push(3'b001, 1'b1, 8'h11, 8'h00);
        push(3'b010, 1'b0, 8'h7E, 8'h7E);
        push(3'b100, 1'b1, 8'h33, 8'h7E);
        push(3'b001, 1'b1, 8'h11, 8'h7E);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ngr = 0; cyc = 0; prev_g = 3'b000;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            @(negedge clk);
            cyc++;
            if (gnt != 3'b000 && prev_g == 3'b000) begin
                t[ngr] = cyc;
                ngr++;
                if (ngr == 4) req = 3'b000;
            end
            prev_g = gnt;
        end
        chk("rr_count", 32'(ngr), 32'd4);
        chk("rr_first", 32'(t[0]), 32'd1);
        chk("rr_gap1", 32'(t[1] - t[0]), 32'd4);
        chk("rr_gap2", 32'(t[2] - t[1]), 32'd4);
        chk("rr_gap3", 32'(t[3] - t[2]), 32'd4);
        wait_idle();

        // Reset in the first XFER cycle of a write aborts it without done.
        req = 3'b001; wr = 3'b001; wdata[7:0] = 8'h99;
        push(3'b001, 1'b1, 8'h99, 8'h7E);
        wait_gnt(3'b001);
        rst = 1'b1; req = 3'b011; wr = 3'b010; wdata[15:8] = 8'hB7; uio_in = 8'h4D;
        push(3'b001, 1'b0, 8'h4D, 8'h4D);
        push(3'b010, 1'b1, 8'hB7, 8'h4D);
        @(negedge clk);
        chk("abort_oe", 32'(uio_oe), 32'h00);
        chk("abort_gnt", 32'(gnt), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'h00);
        rst = 1'b0;
        @(negedge clk);
        chk("post_abort_done", 32'(done), 32'd0);
        chk("post_abort_gnt", 32'(gnt), 32'b001);
        wait_gnt(3'b010);
        req = 3'b000;
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
